// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and helpers used by the top level and the sequential divider.
package mdu_pkg;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'b000,
        MDU_MULTU = 3'b001,
        MDU_DIV   = 3'b010,
        MDU_DIVU  = 3'b011,
        MDU_MADD  = 3'b100,
        MDU_MSUB  = 3'b101,
        MDU_MTHI  = 3'b110,
        MDU_MTLO  = 3'b111
    } mdu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIX  = 2'b11
    } mdu_state_e;

    localparam int MDU_WIDTH = 32;

    // Counter must hold the value WIDTH itself, hence WIDTH+1.
    function automatic int div_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

    localparam int MDU_DIV_CNT_W = div_cnt_w(MDU_WIDTH);

    function automatic logic op_is_signed(input mdu_op_e op);
        return (op != MDU_MULTU) && (op != MDU_DIVU);
    endfunction

endpackage

// File: rtl/mul_div_unit_seq_divider.sv
// Unsigned radix-2 restoring divider: one quotient bit per cycle, WIDTH cycles.
// done is high in the cycle of the final iteration; results are valid from the next cycle.
module seq_divider
    import mdu_pkg::*;
#(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             load,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             done
);

    localparam int CNT_W = div_cnt_w(WIDTH);

    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             active_q, active_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;

    always_comb begin
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        // Partial remainder shifted left with the next dividend bit pulled in from the quotient register.
        shifted  = {rem_q, quo_q[WIDTH-1]};
        diff     = shifted - {1'b0, dvs_q};

        if (abort) begin
            active_d = 1'b0;
            cnt_d    = '0;
        end else if (load) begin
            quo_d    = dividend;
            rem_d    = '0;
            dvs_d    = divisor;
            cnt_d    = CNT_W'(WIDTH);
            active_d = 1'b1;
        end else if (active_q) begin
            if (diff[WIDTH]) begin
                rem_d = shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end else begin
                rem_d = diff[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            active_q <= 1'b0;
        end else begin
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

    assign done      = active_q && (cnt_q == CNT_W'(1));
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO: pipelined multiply with MADD/MSUB
// accumulation, iterative signed/unsigned divide, and MTHI/MTLO moves.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH      = MDU_WIDTH,
    parameter int MUL_STAGES = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Flush,
    output logic             Busy,
    output logic             Done,
    output logic             DivZero,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int MCNT_W = $clog2(MUL_STAGES + 1);
    localparam int PW     = 2 * WIDTH;

    mdu_state_e       state_q, state_d;
    mdu_op_e          op_q, op_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             divzero_q, divzero_d;
    logic [MCNT_W-1:0] mcnt_q, mcnt_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    mdu_op_e          op_in;
    logic             in_signed;
    logic [PW-1:0]    a_ext, b_ext, prod_comb;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic             mul_start;
    logic [PW-1:0]    mul_src;
    mdu_op_e          mul_op;
    logic [PW-1:0]    mul_res;
    logic             div_load, div_abort, div_done;
    logic [WIDTH-1:0] div_quo, div_rem;
    logic [WIDTH-1:0] q_fix, r_fix;

    assign op_in     = mdu_op_e'(Op);
    assign in_signed = op_is_signed(op_in);

    // Sign- or zero-extend to full product width; the truncated product is exact mod 2^PW.
    assign a_ext     = in_signed ? {{WIDTH{A[WIDTH-1]}}, A} : {{WIDTH{1'b0}}, A};
    assign b_ext     = in_signed ? {{WIDTH{B[WIDTH-1]}}, B} : {{WIDTH{1'b0}}, B};
    assign prod_comb = a_ext * b_ext;

    assign a_mag = (in_signed && A[WIDTH-1]) ? ('0 - A) : A;
    assign b_mag = (in_signed && B[WIDTH-1]) ? ('0 - B) : B;

    generate
        if (MUL_STAGES == 1) begin : g_mul_direct
            assign mul_src = prod_comb;
        end else begin : g_mul_pipe
            logic [MUL_STAGES-2:0][PW-1:0] stage_q, stage_d;

            assign stage_d[0] = mul_start ? prod_comb : stage_q[0];
            for (genvar gi = 1; gi < MUL_STAGES - 1; gi++) begin : g_stage
                assign stage_d[gi] = stage_q[gi-1];
            end

            always_ff @(posedge Clk) begin
                if (Reset) begin
                    stage_q <= '0;
                end else begin
                    stage_q <= stage_d;
                end
            end

            assign mul_src = stage_q[MUL_STAGES-2];
        end
    endgenerate

    // With a single stage the write happens on the accept edge, so the op comes straight from the port.
    assign mul_op = (state_q == IDLE) ? op_in : op_q;

    always_comb begin
        case (mul_op)
            MDU_MADD: mul_res = {hi_q, lo_q} + mul_src;
            MDU_MSUB: mul_res = {hi_q, lo_q} - mul_src;
            default:  mul_res = mul_src;
        endcase
    end

    seq_divider #(
        .WIDTH(WIDTH)
    ) u_div (
        .clk      (Clk),
        .srst     (Reset),
        .load     (div_load),
        .abort    (div_abort),
        .dividend (a_mag),
        .divisor  (b_mag),
        .quotient (div_quo),
        .remainder(div_rem),
        .done     (div_done)
    );

    assign q_fix = qneg_q ? ('0 - div_quo) : div_quo;
    assign r_fix = rneg_q ? ('0 - div_rem) : div_rem;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        done_d    = 1'b0;
        divzero_d = 1'b0;
        mcnt_d    = mcnt_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        div_load  = 1'b0;
        div_abort = 1'b0;
        mul_start = 1'b0;

        case (state_q)
            IDLE: begin
                if (Start && !Flush) begin
                    op_d = op_in;
                    case (op_in)
                        MDU_MULT, MDU_MULTU, MDU_MADD, MDU_MSUB: begin
                            mul_start = 1'b1;
                            if (MUL_STAGES == 1) begin
                                {hi_d, lo_d} = mul_res;
                                done_d       = 1'b1;
                            end else begin
                                state_d = MUL;
                                mcnt_d  = MCNT_W'(MUL_STAGES - 1);
                            end
                        end
                        MDU_DIV, MDU_DIVU: begin
                            if (B == '0) begin
                                done_d    = 1'b1;
                                divzero_d = 1'b1;
                            end else begin
                                div_load = 1'b1;
                                qneg_d   = in_signed && (A[WIDTH-1] ^ B[WIDTH-1]);
                                rneg_d   = in_signed && A[WIDTH-1];
                                state_d  = DIV;
                            end
                        end
                        MDU_MTHI: begin
                            hi_d   = A;
                            done_d = 1'b1;
                        end
                        MDU_MTLO: begin
                            lo_d   = A;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            MUL: begin
                if (Flush) begin
                    state_d = IDLE;
                end else if (mcnt_q == MCNT_W'(1)) begin
                    {hi_d, lo_d} = mul_res;
                    done_d       = 1'b1;
                    state_d      = IDLE;
                end else begin
                    mcnt_d = mcnt_q - MCNT_W'(1);
                end
            end
            DIV: begin
                if (Flush) begin
                    div_abort = 1'b1;
                    state_d   = IDLE;
                end else if (div_done) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                if (!Flush) begin
                    hi_d   = r_fix;
                    lo_d   = q_fix;
                    done_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q   <= IDLE;
            op_q      <= MDU_MULT;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
            divzero_q <= 1'b0;
            mcnt_q    <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            done_q    <= done_d;
            divzero_q <= divzero_d;
            mcnt_q    <= mcnt_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
        end
    end

    assign Busy    = (state_q != IDLE);
    assign Done    = done_q;
    assign DivZero = divzero_q;
    assign HI      = hi_q;
    assign LO      = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: transaction-level model checked every cycle
// plus directed vectors with hand-computed HI/LO and latency expectations.
module tb_mul_div_unit;

    localparam int W  = 32;
    localparam int MS = 2;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MSUB  = 3'd5;
    localparam logic [2:0] OP_MTHI  = 3'd6;
    localparam logic [2:0] OP_MTLO  = 3'd7;

    logic          clk = 1'b0;
    logic          rst, start, flush;
    logic [2:0]    op;
    logic [W-1:0]  a, b;
    logic          busy, done, dz;
    logic [W-1:0]  hi, lo;

    always #5 clk = ~clk;

    mul_div_unit #(.WIDTH(W), .MUL_STAGES(MS)) dut (
        .Clk    (clk),
        .Reset  (rst),
        .Start  (start),
        .Op     (op),
        .A      (a),
        .B      (b),
        .Flush  (flush),
        .Busy   (busy),
        .Done   (done),
        .DivZero(dz),
        .HI     (hi),
        .LO     (lo)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit check_en = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endfunction

    // Model: architectural HI/LO plus at most one pending result with its completion cycle.
    logic [W-1:0] m_hi = '0, m_lo = '0;
    bit           m_pend = 1'b0;
    int           m_done_cyc = 0;
    logic [W-1:0] m_phi, m_plo;
    bit           m_pdz;

    task automatic model_issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                               output int lat, output logic [W-1:0] rh, output logic [W-1:0] rl,
                               output bit rdz);
        int          xi, yi;
        longint      sx, sy, q, r;
        logic [63:0] ux, uy, res, acc;
        xi  = x;
        yi  = y;
        sx  = xi;
        sy  = yi;
        ux  = {32'h0, x};
        uy  = {32'h0, y};
        acc = {m_hi, m_lo};
        rdz = 1'b0;
        rh  = m_hi;
        rl  = m_lo;
        lat = MS;
        case (o)
            OP_MULT:  begin res = sx * sy;        {rh, rl} = res; end
            OP_MULTU: begin res = ux * uy;        {rh, rl} = res; end
            OP_MADD:  begin res = acc + (sx * sy); {rh, rl} = res; end
            OP_MSUB:  begin res = acc - (sx * sy); {rh, rl} = res; end
            OP_DIV, OP_DIVU: begin
                if (y == '0) begin
                    lat = 1;
                    rdz = 1'b1;
                end else begin
                    lat = W + 2;
                    if (o == OP_DIV) begin
                        q = sx / sy;
                        r = sx % sy;
                    end else begin
                        q = longint'(ux / uy);
                        r = longint'(ux % uy);
                    end
                    rl = q[31:0];
                    rh = r[31:0];
                end
            end
            OP_MTHI: begin lat = 1; rh = x; end
            default: begin lat = 1; rl = x; end
        endcase
    endtask

    always @(negedge clk) begin : cmp
        bit           e_done, e_dz, e_busy, p_dz;
        int           lat;
        logic [W-1:0] p_hi, p_lo;
        e_done = m_pend && (cyc == m_done_cyc);
        e_dz   = e_done && m_pdz;
        if (e_done) begin
            m_hi   = m_phi;
            m_lo   = m_plo;
            m_pend = 1'b0;
        end
        e_busy = m_pend;
        if (check_en) begin
            chk("model_busy", busy, e_busy);
            chk("model_done", done, e_done);
            chk("model_divzero", dz, e_dz);
            chk("model_hi", hi, m_hi);
            chk("model_lo", lo, m_lo);
        end
        if (rst) begin
            m_hi   = '0;
            m_lo   = '0;
            m_pend = 1'b0;
        end else if (flush) begin
            m_pend = 1'b0;
        end else if (start && !m_pend) begin
            model_issue(op, a, b, lat, p_hi, p_lo, p_dz);
            m_pend     = 1'b1;
            m_done_cyc = cyc + lat;
            m_phi      = p_hi;
            m_plo      = p_lo;
            m_pdz      = p_dz;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output int t);
        op    = o;
        a     = x;
        b     = y;
        start = 1'b1;
        t     = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, output int t);
        int n;
        n = 0;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        chk({name, "_done_seen"}, done, 1'b1);
        t = cyc;
    endtask

    int t0, t1;

    initial begin
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = '0; a = '0; b = '0;
        tick();
        check_en = 1'b1;
        tick();
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        rst = 1'b0;
        tick();

        // Signed and unsigned multiply of the same bit patterns
        issue(OP_MULT, 32'hFFFFFFFD, 32'd5, t0);
        wait_done("mult", t1);
        $display("MULT  -3*5     lat=%0d HI=%h LO=%h", t1 - t0, hi, lo);
        chk("mult_latency", t1 - t0, 2);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFF1);
        issue(OP_MULTU, 32'hFFFFFFFD, 32'd5, t0);
        wait_done("multu", t1);
        $display("MULTU 0xFFFFFFFD*5 lat=%0d HI=%h LO=%h", t1 - t0, hi, lo);
        chk("multu_hi", hi, 32'h00000004);
        chk("multu_lo", lo, 32'hFFFFFFF1);

        issue(OP_DIVU, 32'd100, 32'd7, t0);
        chk("divu_busy_first", busy, 1);
        wait_done("divu", t1);
        $display("DIVU  100/7    lat=%0d HI=%h LO=%h", t1 - t0, hi, lo);
        chk("divu_latency", t1 - t0, 34);
        chk("divu_busy_in_done", busy, 0);
        chk("divu_lo", lo, 32'd14);
        chk("divu_hi", hi, 32'd2);

        issue(OP_DIV, 32'hFFFFFFF9, 32'd2, t0);
        wait_done("div_neg", t1);
        $display("DIV   -7/2     lat=%0d HI=%h LO=%h", t1 - t0, hi, lo);
        chk("div_neg_lo", lo, 32'hFFFFFFFD);
        chk("div_neg_hi", hi, 32'hFFFFFFFF);
        issue(OP_DIV, 32'h80000000, 32'hFFFFFFFF, t0);
        wait_done("div_min", t1);
        $display("DIV   MIN/-1   lat=%0d HI=%h LO=%h", t1 - t0, hi, lo);
        chk("div_min_lo", lo, 32'h80000000);
        chk("div_min_hi", hi, 32'h0);

        issue(OP_MTHI, 32'h55, 32'd0, t0);
        wait_done("mthi55", t1);
        issue(OP_MTLO, 32'h55, 32'd0, t0);
        wait_done("mtlo55", t1);
        issue(OP_DIV, 32'd9, 32'd0, t0);
        wait_done("divzero", t1);
        $display("DIV   9/0      lat=%0d DivZero=%0d HI=%h LO=%h", t1 - t0, dz, hi, lo);
        chk("divzero_latency", t1 - t0, 1);
        chk("divzero_flag", dz, 1);
        chk("divzero_hi", hi, 32'h55);
        chk("divzero_lo", lo, 32'h55);

        issue(OP_MULT, 32'd3, 32'd4, t0);
        wait_done("mult34", t1);
        issue(OP_MADD, 32'd2, 32'd5, t0);
        chk("madd_issue_in_done_cycle", t0, t1);
        wait_done("madd", t1);
        $display("MADD  12+2*5   lat=%0d HI=%h LO=%h", t1 - t0, hi, lo);
        chk("madd_lo", lo, 32'd22);
        chk("madd_hi", hi, 32'd0);
        issue(OP_MSUB, 32'd23, 32'd1, t0);
        wait_done("msub", t1);
        $display("MSUB  22-23    lat=%0d HI=%h LO=%h", t1 - t0, hi, lo);
        chk("msub_lo", lo, 32'hFFFFFFFF);
        chk("msub_hi", hi, 32'hFFFFFFFF);
        issue(OP_MTHI, 32'hAB, 32'd0, t0);
        wait_done("mthi", t1);
        $display("MTHI  0xAB     lat=%0d HI=%h LO=%h", t1 - t0, hi, lo);
        chk("mthi_latency", t1 - t0, 1);
        chk("mthi_hi", hi, 32'hAB);
        chk("mthi_lo", lo, 32'hFFFFFFFF);

        // Flush of a divide, with an ignored Start while busy
        issue(OP_DIV, 32'd1000, 32'd3, t0);
        repeat (4) tick();
        op = OP_MTLO; a = 32'h1234; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        chk("flush_at_cycle", cyc - t0, 10);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        $display("FLUSH DIV at T+10 busy=%0d done=%0d HI=%h LO=%h", busy, done, hi, lo);
        chk("flush_busy", busy, 0);
        chk("flush_done", done, 0);
        chk("flush_hi", hi, 32'hAB);
        chk("flush_lo", lo, 32'hFFFFFFFF);
        repeat (40) tick();

        // Flush coinciding with Start drops the Start
        op = OP_MTLO; a = 32'h99; start = 1'b1; flush = 1'b1;
        tick();
        start = 1'b0; flush = 1'b0;
        $display("START+FLUSH MTLO done=%0d LO=%h", done, lo);
        chk("startflush_done", done, 0);
        chk("startflush_lo", lo, 32'hFFFFFFFF);

        // Flush in the multiply write cycle suppresses the write
        issue(OP_MULT, 32'd7, 32'd7, t0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        $display("FLUSH MULT write cycle done=%0d LO=%h", done, lo);
        chk("mulflush_done", done, 0);
        chk("mulflush_lo", lo, 32'hFFFFFFFF);
        tick();

        // Reset in the middle of a divide
        issue(OP_DIV, 32'd50, 32'd5, t0);
        repeat (19) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        $display("RESET mid-DIV busy=%0d done=%0d HI=%h LO=%h", busy, done, hi, lo);
        chk("midreset_busy", busy, 0);
        chk("midreset_done", done, 0);
        chk("midreset_hi", hi, 0);
        chk("midreset_lo", lo, 0);
        repeat (3) tick();

        issue(OP_MULTU, 32'h00010000, 32'h00010000, t0);
        wait_done("recover", t1);
        $display("MULTU 2^16*2^16 lat=%0d HI=%h LO=%h", t1 - t0, hi, lo);
        chk("recover_hi", hi, 32'd1);
        chk("recover_lo", lo, 32'd0);
        repeat (3) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
